// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer between the CPU load/store port (m0)
// and the loader/debug port (m1) for a shared single-port data memory.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0]    LAT_LOAD = 4'(RD_LAT - 1);
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              last_owner;
    logic              we_q;
    logic              oor_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic req_any;
    logic sel;
    logic oor0;
    logic oor1;

    assign req_any = m0_req | m1_req;
    assign oor0    = {1'b0, m0_addr} >= DEPTH_LIMIT;
    assign oor1    = {1'b0, m1_addr} >= DEPTH_LIMIT;

    // On contention the port that did not win last time is served.
    always_comb begin
        sel = 1'b0;
        if (m0_req && m1_req) begin
            sel = ~last_owner;
        end else if (m1_req) begin
            sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = ACCESS;
            ACCESS:  state_next = we_q ? IDLE : WAIT;
            WAIT:    if (lat_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched once in IDLE so later input changes cannot disturb the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= 4'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner      <= sel;
                        last_owner <= sel;
                        we_q       <= sel ? m1_we    : m0_we;
                        addr_q     <= sel ? m1_addr  : m0_addr;
                        wdata_q    <= sel ? m1_wdata : m0_wdata;
                        oor_q      <= sel ? oor1     : oor0;
                    end
                end
                ACCESS: begin
                    lat_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        if (owner) begin
                            m1_rdata_q <= oor_q ? '0 : mem_rdata;
                        end else begin
                            m0_rdata_q <= oor_q ? '0 : mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    logic in_access;
    logic in_resp;
    logic err_now;

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);
    assign err_now   = oor_q & ((in_access & we_q) | in_resp);

    assign m0_gnt    = in_access & ~owner;
    assign m1_gnt    = in_access &  owner;
    assign m0_rvalid = in_resp   & ~owner;
    assign m1_rvalid = in_resp   &  owner;
    assign m0_err    = err_now   & ~owner;
    assign m1_err    = err_now   &  owner;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

    // Out-of-range accesses never reach the memory.
    assign mem_en    = in_access & ~oor_q;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (default, 9-bit address, RD_LAT=3)
// share one set of requester stimulus, each with its own behavioural memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
    logic [7:0]  a_mem_addr;

    logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
    logic [8:0]  b_mem_addr;

    logic        c_m0_gnt, c_m0_rvalid, c_m0_err, c_m1_gnt, c_m1_rvalid, c_m1_err;
    logic        c_mem_en, c_mem_we, c_busy;
    logic [31:0] c_m0_rdata, c_m1_rdata, c_mem_wdata, c_mem_rdata;
    logic [7:0]  c_mem_addr;

    dmem_arbiter u_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr[7:0]), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr[7:0]), .m1_wdata(m1_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    dmem_arbiter #(.ADDR_W(9), .DEPTH(256), .RD_LAT(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    dmem_arbiter #(.RD_LAT(3)) u_c (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr[7:0]), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr[7:0]), .m1_wdata(m1_wdata),
        .m0_gnt(c_m0_gnt), .m0_rvalid(c_m0_rvalid), .m0_rdata(c_m0_rdata), .m0_err(c_m0_err),
        .m1_gnt(c_m1_gnt), .m1_rvalid(c_m1_rvalid), .m1_rdata(c_m1_rdata), .m1_err(c_m1_err),
        .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
        .mem_rdata(c_mem_rdata), .busy(c_busy)
    );

    // Memory models drive a junk pattern whenever no read data is due, so mistimed sampling shows up.
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    logic [31:0] c_mem [256];
    logic [31:0] a_rd, b_rd, c_p1, c_p2, c_p3;

    assign a_mem_rdata = a_rd;
    assign b_mem_rdata = b_rd;
    assign c_mem_rdata = c_p3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) a_mem[i] <= 32'(i * 5);
            a_rd <= 32'hBAD0_0000;
        end else begin
            a_rd <= 32'hBAD0_0000;
            if (a_mem_en && a_mem_we) a_mem[a_mem_addr] <= a_mem_wdata;
            else if (a_mem_en) a_rd <= a_mem[a_mem_addr];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= 32'hB000_0000 | 32'(i);
            b_rd <= 32'hBAD0_0000;
        end else begin
            b_rd <= 32'hBAD0_0000;
            if (b_mem_en && b_mem_we) b_mem[b_mem_addr[7:0]] <= b_mem_wdata;
            else if (b_mem_en) b_rd <= b_mem[b_mem_addr[7:0]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) c_mem[i] <= 32'(i * 10);
            c_p1 <= 32'hBAD0_0000;
            c_p2 <= 32'hBAD0_0000;
            c_p3 <= 32'hBAD0_0000;
        end else begin
            c_p1 <= 32'hBAD0_0000;
            c_p2 <= c_p1;
            c_p3 <= c_p2;
            if (c_mem_en && c_mem_we) c_mem[c_mem_addr] <= c_mem_wdata;
            else if (c_mem_en) c_p1 <= c_mem[c_mem_addr];
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_port_flags: got %b want 000000", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err}); end
        n_cmp++; if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== 42'b0) begin n_fail++; $display("[TB] FAIL reset_mem_bus: got en=%b we=%b addr=%0h wdata=%0h want all 0", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata); end
        n_cmp++; if ({a_m0_rdata, a_m1_rdata} !== 64'b0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %0h/%0h want 0/0", a_m0_rdata, a_m1_rdata); end
        n_cmp++; if ({a_busy, b_busy, c_busy} !== 3'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 000", {a_busy, b_busy, c_busy}); end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd5; m0_wdata = 32'h46;
        cyc();
        n_cmp++; if ({a_mem_en, a_mem_we} !== 2'b11) begin n_fail++; $display("[TB] FAIL wr_mem_en_we: got %b want 11", {a_mem_en, a_mem_we}); end
        n_cmp++; if (a_mem_addr !== 8'd5) begin n_fail++; $display("[TB] FAIL wr_mem_addr: got %0h want 5", a_mem_addr); end
        n_cmp++; if (a_mem_wdata !== 32'h46) begin n_fail++; $display("[TB] FAIL wr_mem_wdata: got %0h want 46", a_mem_wdata); end
        n_cmp++; if ({a_m0_gnt, a_m1_gnt, a_m0_err} !== 3'b100) begin n_fail++; $display("[TB] FAIL wr_gnt: got m0_gnt/m1_gnt/m0_err=%b want 100", {a_m0_gnt, a_m1_gnt, a_m0_err}); end
        m0_req = 1'b0;
        cyc();
        n_cmp++; if ({a_busy, a_m0_gnt, a_mem_en} !== 3'b000) begin n_fail++; $display("[TB] FAIL wr_done: got busy/gnt/mem_en=%b want 000", {a_busy, a_m0_gnt, a_mem_en}); end
        n_cmp++; if (a_mem[5] !== 32'h46) begin n_fail++; $display("[TB] FAIL wr_stored: got %0h want 46", a_mem[5]); end
    endtask

    task automatic test_read();
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd2;
        cyc();
        n_cmp++; if ({a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 8'd2}) begin n_fail++; $display("[TB] FAIL rd_access: got en=%b we=%b addr=%0h want 1 0 2", a_mem_en, a_mem_we, a_mem_addr); end
        n_cmp++; if ({a_m1_gnt, a_m0_gnt} !== 2'b10) begin n_fail++; $display("[TB] FAIL rd_gnt: got m1/m0=%b want 10", {a_m1_gnt, a_m0_gnt}); end
        m1_req = 1'b0;
        cyc();
        n_cmp++; if ({a_m1_rvalid, a_busy, a_mem_en} !== 3'b010) begin n_fail++; $display("[TB] FAIL rd_wait: got rvalid/busy/mem_en=%b want 010", {a_m1_rvalid, a_busy, a_mem_en}); end
        cyc();
        n_cmp++; if ({a_m1_rvalid, a_m1_err} !== 2'b10) begin n_fail++; $display("[TB] FAIL rd_resp_flags: got rvalid/err=%b want 10", {a_m1_rvalid, a_m1_err}); end
        n_cmp++; if (a_m1_rdata !== 32'd10) begin n_fail++; $display("[TB] FAIL rd_resp_data: got %0d want 10", a_m1_rdata); end
        n_cmp++; if ({a_m0_gnt, a_m0_rvalid, a_m0_err, a_m0_rdata} !== 35'b0) begin n_fail++; $display("[TB] FAIL rd_m0_quiet: got gnt=%b rvalid=%b err=%b rdata=%0h want all 0", a_m0_gnt, a_m0_rvalid, a_m0_err, a_m0_rdata); end
        cyc();
        n_cmp++; if ({a_m1_rvalid, a_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL rd_after: got rvalid/busy=%b want 00", {a_m1_rvalid, a_busy}); end
        n_cmp++; if (a_m1_rdata !== 32'd10) begin n_fail++; $display("[TB] FAIL rd_hold: got %0d want 10", a_m1_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [8];
        exp_gnt = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd10; m0_wdata = 32'd1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd11; m1_wdata = 32'd2;
        for (int c = 0; c < 8; c++) begin
            cyc();
            n_cmp++; if ({a_m0_gnt, a_m1_gnt} !== exp_gnt[c]) begin n_fail++; $display("[TB] FAIL rr_cycle%0d: got m0/m1 gnt=%b want %b", c + 1, {a_m0_gnt, a_m1_gnt}, exp_gnt[c]); end
        end
        idle_inputs();
        cyc();
        n_cmp++; if ({a_mem[10], a_mem[11]} !== {32'd1, 32'd2}) begin n_fail++; $display("[TB] FAIL rr_stored: got %0h/%0h want 1/2", a_mem[10], a_mem[11]); end
    endtask

    task automatic test_read_latency3();
        logic [2:0] exp_flags;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd7;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd3; m1_wdata = 32'h33;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            exp_flags = {c == 1, c == 5, c == 7};
            n_cmp++; if ({c_m0_gnt, c_m0_rvalid, c_m1_gnt} !== exp_flags) begin n_fail++; $display("[TB] FAIL lat3_cycle%0d: got m0_gnt/m0_rvalid/m1_gnt=%b want %b", c, {c_m0_gnt, c_m0_rvalid, c_m1_gnt}, exp_flags); end
            n_cmp++; if (c_busy !== (c != 6)) begin n_fail++; $display("[TB] FAIL lat3_busy%0d: got %b want %b", c, c_busy, c != 6); end
            if (c == 1) begin
                n_cmp++; if ({c_mem_en, c_mem_we, c_mem_addr} !== {2'b10, 8'd7}) begin n_fail++; $display("[TB] FAIL lat3_rd_access: got en=%b we=%b addr=%0h want 1 0 7", c_mem_en, c_mem_we, c_mem_addr); end
                m0_req = 1'b0;
            end
            if (c == 5) begin
                n_cmp++; if ({c_m0_rdata, c_m0_err} !== {32'd70, 1'b0}) begin n_fail++; $display("[TB] FAIL lat3_rdata: got %0d err=%b want 70 err=0", c_m0_rdata, c_m0_err); end
            end
            if (c == 7) begin
                n_cmp++; if ({c_mem_en, c_mem_we, c_mem_addr, c_mem_wdata} !== {2'b11, 8'd3, 32'h33}) begin n_fail++; $display("[TB] FAIL lat3_wr_access: got en=%b we=%b addr=%0h wdata=%0h want 1 1 3 33", c_mem_en, c_mem_we, c_mem_addr, c_mem_wdata); end
                m1_req = 1'b0;
            end
        end
        cyc();
    endtask

    task automatic test_out_of_range();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd2;
        cyc();
        m0_req = 1'b0;
        cyc();
        cyc();
        n_cmp++; if ({b_m0_rvalid, b_m0_err, b_m0_rdata} !== {2'b10, 32'hB000_0002}) begin n_fail++; $display("[TB] FAIL oor_pre_read: got rvalid=%b err=%b rdata=%0h want 1 0 b0000002", b_m0_rvalid, b_m0_err, b_m0_rdata); end
        cyc();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd300;
        cyc();
        n_cmp++; if ({b_m0_gnt, b_m0_err, b_mem_en, b_mem_addr} !== {3'b100, 9'd0}) begin n_fail++; $display("[TB] FAIL oor_rd_access: got gnt=%b err=%b mem_en=%b addr=%0h want 1 0 0 0", b_m0_gnt, b_m0_err, b_mem_en, b_mem_addr); end
        m0_req = 1'b0;
        cyc();
        n_cmp++; if ({b_m0_rvalid, b_mem_en, b_busy} !== 3'b001) begin n_fail++; $display("[TB] FAIL oor_rd_wait: got rvalid/mem_en/busy=%b want 001", {b_m0_rvalid, b_mem_en, b_busy}); end
        cyc();
        n_cmp++; if ({b_m0_rvalid, b_m0_err, b_m0_rdata} !== {2'b11, 32'd0}) begin n_fail++; $display("[TB] FAIL oor_rd_resp: got rvalid=%b err=%b rdata=%0h want 1 1 0", b_m0_rvalid, b_m0_err, b_m0_rdata); end
        cyc();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd260; m1_wdata = 32'd5;
        cyc();
        n_cmp++; if ({b_m1_gnt, b_m1_err, b_mem_en, b_mem_we} !== 4'b1100) begin n_fail++; $display("[TB] FAIL oor_wr: got gnt/err/mem_en/mem_we=%b want 1100", {b_m1_gnt, b_m1_err, b_mem_en, b_mem_we}); end
        m1_req = 1'b0;
        cyc();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd255; m1_wdata = 32'd7;
        cyc();
        n_cmp++; if ({b_m1_gnt, b_m1_err, b_mem_en, b_mem_addr} !== {3'b101, 9'd255}) begin n_fail++; $display("[TB] FAIL edge_wr_255: got gnt=%b err=%b mem_en=%b addr=%0d want 1 0 1 255", b_m1_gnt, b_m1_err, b_mem_en, b_mem_addr); end
        m1_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd2;
        cyc();
        m1_req = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (a_m1_rdata !== 32'd10) begin n_fail++; $display("[TB] FAIL rw_pre_read: got %0d want 10", a_m1_rdata); end
        cyc();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd2;
        cyc();
        m1_req = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_busy, a_m1_gnt, a_m1_rvalid, a_mem_en, a_m1_rdata} !== 36'b0) begin n_fail++; $display("[TB] FAIL rw_async_clear: got busy=%b gnt=%b rvalid=%b mem_en=%b rdata=%0h want all 0", a_busy, a_m1_gnt, a_m1_rvalid, a_mem_en, a_m1_rdata); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_cmp++; if ({a_m1_rvalid, a_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL rw_in_reset%0d: got rvalid/busy=%b want 00", c, {a_m1_rvalid, a_busy}); end
        end
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd20; m0_wdata = 32'd8;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd21; m1_wdata = 32'd9;
        cyc();
        n_cmp++; if ({a_m0_gnt, a_m1_gnt, a_m1_rvalid} !== 3'b100) begin n_fail++; $display("[TB] FAIL rw_first_grant: got m0_gnt/m1_gnt/m1_rvalid=%b want 100", {a_m0_gnt, a_m1_gnt, a_m1_rvalid}); end
        m0_req = 1'b0;
        cyc();
        cyc();
        n_cmp++; if ({a_m0_gnt, a_m1_gnt, a_m1_rvalid} !== 3'b010) begin n_fail++; $display("[TB] FAIL rw_second_grant: got m0_gnt/m1_gnt/m1_rvalid=%b want 010", {a_m0_gnt, a_m1_gnt, a_m1_rvalid}); end
        m1_req = 1'b0;
        cyc();
    endtask

    initial begin
        idle_inputs();
        $display("[TB] dmem_arbiter directed test start");
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_read_latency3();
        test_out_of_range();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
